// File: rtl/x2050mvr.sv
// Mover stage of the 2050 data flow: stage 1 registers U/V/fn/dest, stage 2 applies
// the mover function into W and writes W back into MD, F or XTR.
module x2050mvr (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_hold,
  input  logic       i_valid,
  input  logic [7:0] i_u_reg,
  input  logic [7:0] i_v_reg,
  input  logic [3:0] i_fn,
  input  logic [2:0] i_dest,
  input  logic       i_dd_sample,
  output logic [7:0] o_w_reg,
  output logic       o_w_valid,
  output logic [3:0] o_md_reg,
  output logic [3:0] o_f_reg,
  output logic [7:0] o_xtr,
  output logic       o_w_zero,
  output logic       o_w_lo_invalid,
  output logic       o_fn_err,
  output logic       o_dd_ack
);

  logic       s1_valid;
  logic [7:0] s1_u;
  logic [7:0] s1_v;
  logic [3:0] s1_fn;
  logic [2:0] s1_dest;
  logic       s1_dd;

  logic [7:0] w_next;
  logic       fn_rsvd;

  always_comb begin
    w_next  = 8'h00;
    fn_rsvd = 1'b0;
    case (s1_fn)
      4'd0:    w_next = s1_u | s1_v;
      4'd1:    w_next = s1_u & s1_v;
      4'd2:    w_next = s1_u ^ s1_v;
      4'd3:    w_next = s1_u;
      4'd4:    w_next = s1_v;
      4'd5:    w_next = {s1_u[7:4], s1_v[3:0]};
      4'd6:    w_next = {s1_v[7:4], s1_u[3:0]};
      4'd7:    w_next = {s1_u[3:0], s1_u[7:4]};
      4'd8:    w_next = {4'h0, s1_u[7:4]};
      4'd9:    w_next = {s1_u[3:0], 4'h0};
      default: fn_rsvd = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      s1_valid <= 1'b0;
      s1_u     <= 8'h00;
      s1_v     <= 8'h00;
      s1_fn    <= 4'h0;
      s1_dest  <= 3'h0;
      s1_dd    <= 1'b0;
    end else if (!i_hold) begin
      s1_valid <= i_valid;
      if (i_valid) begin
        s1_u    <= i_u_reg;
        s1_v    <= i_v_reg;
        s1_fn   <= i_fn;
        s1_dest <= i_dest;
        s1_dd   <= i_dd_sample;
      end
    end
  end

  // No bypass: the upstream block sees MD/F/XTR only after this edge.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_w_reg        <= 8'h00;
      o_w_valid      <= 1'b0;
      o_md_reg       <= 4'h0;
      o_f_reg        <= 4'h0;
      o_xtr          <= 8'h00;
      o_w_zero       <= 1'b0;
      o_w_lo_invalid <= 1'b0;
      o_fn_err       <= 1'b0;
      o_dd_ack       <= 1'b0;
    end else if (!i_hold) begin
      if (s1_valid) begin
        o_w_reg        <= w_next;
        o_w_valid      <= 1'b1;
        o_w_zero       <= (w_next == 8'h00);
        o_w_lo_invalid <= (w_next[3:0] > 4'd9);
        o_fn_err       <= fn_rsvd;
        o_dd_ack       <= s1_dd;
        case (s1_dest)
          3'd1: o_md_reg <= w_next[3:0];
          3'd2: o_f_reg  <= w_next[3:0];
          3'd3: o_xtr    <= w_next;
          3'd4: begin
            o_md_reg <= w_next[7:4];
            o_f_reg  <= w_next[3:0];
          end
          default: ;
        endcase
      end else begin
        o_w_valid      <= 1'b0;
        o_w_zero       <= 1'b0;
        o_w_lo_invalid <= 1'b0;
        o_fn_err       <= 1'b0;
        o_dd_ack       <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_x2050mvr.sv
// Bench for the 2050 mover stage: vector table, directed hazard/hold/DD sequences,
// and randomized traffic checked against an operation-level reference model.
module tb_x2050mvr;

  logic       clk = 1'b0;
  logic       rst, hold, valid, dd;
  logic [7:0] u, v;
  logic [3:0] fn;
  logic [2:0] dest;

  logic [7:0] o_w_reg, o_xtr;
  logic [3:0] o_md_reg, o_f_reg;
  logic       o_w_valid, o_w_zero, o_w_lo_invalid, o_fn_err, o_dd_ack;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  x2050mvr dut (
    .i_clk(clk), .i_reset(rst), .i_hold(hold), .i_valid(valid),
    .i_u_reg(u), .i_v_reg(v), .i_fn(fn), .i_dest(dest), .i_dd_sample(dd),
    .o_w_reg(o_w_reg), .o_w_valid(o_w_valid), .o_md_reg(o_md_reg),
    .o_f_reg(o_f_reg), .o_xtr(o_xtr), .o_w_zero(o_w_zero),
    .o_w_lo_invalid(o_w_lo_invalid), .o_fn_err(o_fn_err), .o_dd_ack(o_dd_ack)
  );

  // Reference model: one pending operation plus the architectural outputs.
  logic [7:0] m_w, m_xtr;
  logic [3:0] m_md, m_f;
  logic       m_wv, m_zero, m_lo, m_err, m_ack;
  logic       p_valid, p_dd;
  logic [7:0] p_u, p_v;
  logic [3:0] p_fn;
  logic [2:0] p_dest;

  function automatic int ref_w(input int a, input int b, input int f);
    case (f)
      0: return a | b;
      1: return a & b;
      2: return a ^ b;
      3: return a;
      4: return b;
      5: return (a / 16) * 16 + b % 16;
      6: return (b / 16) * 16 + a % 16;
      7: return (a % 16) * 16 + a / 16;
      8: return a / 16;
      9: return (a % 16) * 16;
      default: return 0;
    endcase
  endfunction

  task automatic model_edge();
    int w;
    if (rst) begin
      m_w = 0; m_xtr = 0; m_md = 0; m_f = 0;
      m_wv = 0; m_zero = 0; m_lo = 0; m_err = 0; m_ack = 0;
      p_valid = 0;
    end else if (!hold) begin
      if (p_valid) begin
        w = ref_w(int'(p_u), int'(p_v), int'(p_fn));
        m_w = 8'(w); m_wv = 1; m_zero = (w == 0); m_lo = (w % 16) > 9;
        m_err = (p_fn > 9); m_ack = p_dd;
        case (p_dest)
          3'd1: m_md = 4'(w % 16);
          3'd2: m_f = 4'(w % 16);
          3'd3: m_xtr = 8'(w);
          3'd4: begin m_md = 4'(w / 16); m_f = 4'(w % 16); end
          default: ;
        endcase
      end else begin
        m_wv = 0; m_ack = 0;
      end
      p_valid = valid;
      if (valid) begin
        p_u = u; p_v = v; p_fn = fn; p_dest = dest; p_dd = dd;
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_model();
    check("m_w_valid", 32'(o_w_valid), 32'(m_wv));
    check("m_w_reg", 32'(o_w_reg), 32'(m_w));
    check("m_md", 32'(o_md_reg), 32'(m_md));
    check("m_f", 32'(o_f_reg), 32'(m_f));
    check("m_xtr", 32'(o_xtr), 32'(m_xtr));
    check("m_dd_ack", 32'(o_dd_ack), 32'(m_ack));
    if (m_wv) begin
      check("m_zero", 32'(o_w_zero), 32'(m_zero));
      check("m_lo_inv", 32'(o_w_lo_invalid), 32'(m_lo));
      check("m_fn_err", 32'(o_fn_err), 32'(m_err));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic issue(input logic [7:0] uu, input logic [7:0] vv, input logic [3:0] ff,
                       input logic [2:0] dd_sel, input logic dds);
    valid = 1'b1; u = uu; v = vv; fn = ff; dest = dd_sel; dd = dds;
  endtask

  task automatic idle();
    valid = 1'b0; dd = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_w"}, 32'(o_w_reg), 0);
    check({tag, "_wv"}, 32'(o_w_valid), 0);
    check({tag, "_md"}, 32'(o_md_reg), 0);
    check({tag, "_f"}, 32'(o_f_reg), 0);
    check({tag, "_xtr"}, 32'(o_xtr), 0);
    check({tag, "_zero"}, 32'(o_w_zero), 0);
    check({tag, "_lo"}, 32'(o_w_lo_invalid), 0);
    check({tag, "_err"}, 32'(o_fn_err), 0);
    check({tag, "_ack"}, 32'(o_dd_ack), 0);
  endtask

  typedef struct {
    logic [7:0] u;
    logic [7:0] v;
    logic [3:0] fn;
    logic [7:0] exp_w;
    logic       exp_err;
    logic       exp_zero;
  } vec_t;

  vec_t tbl[11];

  initial begin
    tbl[0]  = '{8'h5A, 8'hC3, 4'd0,  8'hDB, 1'b0, 1'b0};
    tbl[1]  = '{8'h5A, 8'hC3, 4'd1,  8'h42, 1'b0, 1'b0};
    tbl[2]  = '{8'h5A, 8'hC3, 4'd2,  8'h99, 1'b0, 1'b0};
    tbl[3]  = '{8'h5A, 8'hC3, 4'd3,  8'h5A, 1'b0, 1'b0};
    tbl[4]  = '{8'h5A, 8'hC3, 4'd4,  8'hC3, 1'b0, 1'b0};
    tbl[5]  = '{8'h5A, 8'hC3, 4'd5,  8'h53, 1'b0, 1'b0};
    tbl[6]  = '{8'h5A, 8'hC3, 4'd6,  8'hCA, 1'b0, 1'b0};
    tbl[7]  = '{8'h5A, 8'hC3, 4'd7,  8'hA5, 1'b0, 1'b0};
    tbl[8]  = '{8'h5A, 8'hC3, 4'd8,  8'h05, 1'b0, 1'b0};
    tbl[9]  = '{8'h5A, 8'hC3, 4'd9,  8'hA0, 1'b0, 1'b0};
    tbl[10] = '{8'h5A, 8'hC3, 4'd12, 8'h00, 1'b1, 1'b1};

    rst = 1'b1; hold = 1'b1; valid = 1'b0; dd = 1'b0;
    u = 8'h00; v = 8'h00; fn = 4'h0; dest = 3'h0;
    tick();
    check_all_zero("reset");
    rst = 1'b0; hold = 1'b0;
    tick();

    // Function sweep, issued back-to-back; each result appears 2 edges after issue.
    for (int i = 0; i < 11; i++) begin
      issue(tbl[i].u, tbl[i].v, tbl[i].fn, 3'd0, 1'b0);
      tick();
      if (i == 0) check("sweep_latency", 32'(o_w_valid), 0);
      else begin
        check("sweep_wv", 32'(o_w_valid), 1);
        check("sweep_w", 32'(o_w_reg), 32'(tbl[i-1].exp_w));
        check("sweep_err", 32'(o_fn_err), 32'(tbl[i-1].exp_err));
      end
    end
    idle();
    tick();
    check("rsvd_w", 32'(o_w_reg), 32'(tbl[10].exp_w));
    check("rsvd_err", 32'(o_fn_err), 32'(tbl[10].exp_err));
    check("rsvd_zero", 32'(o_w_zero), 32'(tbl[10].exp_zero));
    tick();
    check("sweep_drain", 32'(o_w_valid), 0);

    // Destination writes.
    issue(8'h7E, 8'h00, 4'd3, 3'd4, 1'b0);
    tick();
    issue(8'h33, 8'h00, 4'd3, 3'd3, 1'b0);
    tick();
    check("dest4_md", 32'(o_md_reg), 32'h7);
    check("dest4_f", 32'(o_f_reg), 32'hE);
    check("dest4_lo", 32'(o_w_lo_invalid), 1);
    idle();
    tick();
    check("dest3_xtr", 32'(o_xtr), 32'h33);
    check("dest3_md", 32'(o_md_reg), 32'h7);
    check("dest3_f", 32'(o_f_reg), 32'hE);
    tick();

    // Back-to-back MD writes with a 3-cycle hold between them.
    issue(8'h01, 8'h00, 4'd3, 3'd1, 1'b0);
    tick();
    for (int k = 0; k < 3; k++) begin
      hold = 1'b1;
      issue(8'hFF, 8'hFF, 4'd3, 3'd1, 1'b1);
      tick();
      check("hold_md", 32'(o_md_reg), 32'h7);
      check("hold_wv", 32'(o_w_valid), 0);
    end
    hold = 1'b0;
    issue(8'h02, 8'h00, 4'd3, 3'd1, 1'b0);
    tick();
    check("b2b_md1", 32'(o_md_reg), 32'h1);
    idle();
    tick();
    check("b2b_md2", 32'(o_md_reg), 32'h2);
    tick();
    check("b2b_nodup", 32'(o_w_valid), 0);

    // DD handshake.
    issue(8'h10, 8'h00, 4'd3, 3'd0, 1'b1);
    tick();
    idle();
    check("dd_e1", 32'(o_dd_ack), 0);
    tick();
    check("dd_e2", 32'(o_dd_ack), 1);
    tick();
    check("dd_one", 32'(o_dd_ack), 0);
    valid = 1'b0; dd = 1'b1;
    tick();
    tick();
    check("dd_noval", 32'(o_dd_ack), 0);
    dd = 1'b0;

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      rst   = ($urandom_range(0, 59) == 0);
      hold  = ($urandom_range(0, 3) == 0);
      valid = ($urandom_range(0, 3) != 0);
      u     = 8'($urandom);
      v     = 8'($urandom);
      fn    = 4'($urandom);
      dest  = 3'($urandom);
      dd    = 1'($urandom);
      tick();
    end
    rst = 1'b0; hold = 1'b0;
    issue(8'hA7, 8'h3C, 4'd0, 3'd4, 1'b1);
    tick();
    tick();

    // Reset overrides hold and flushes state.
    rst = 1'b1; hold = 1'b1;
    tick();
    check_all_zero("reset2");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/x2050mvr.md
Name: x2050mvr

Overview:
- Mover stage of the 2050 data flow. Sits directly downstream of the left mover input decode.
- Registers the U byte from the left mover and the V byte from the right mover input, applies the ROS mover function, and latches the result into the W register.
- Writes W back into the MD, F and XTR registers. Those registers feed back into the left mover input, which closes the loop.
- Two-stage pipeline with a global hold.

Parameters:
- none (all widths are fixed by the 2050 data flow)

Ports:
- i_clk  input  1  system clock; every register updates on its rising edge
- i_reset  input  1  synchronous, active-high reset
- i_hold  input  1  freezes every register in the block, including the output pulses
- i_valid  input  1  U/V/function/destination are valid this cycle
- i_u_reg  input  8  U byte from the left mover input (o_u_reg of the upstream block)
- i_v_reg  input  8  V byte from the right mover input
- i_fn  input  4  mover function code
- i_dest  input  3  W destination select
- i_dd_sample  input  1  upstream is sampling the direct data (DD) input this cycle
- o_w_reg  output  8  W register
- o_w_valid  output  1  o_w_reg updated this cycle
- o_md_reg  output  4  MD register
- o_f_reg  output  4  F register
- o_xtr  output  8  external (XTR) register
- o_w_zero  output  1  W == 0; qualified by o_w_valid
- o_w_lo_invalid  output  1  W[3:0] > 9 (not a valid decimal digit); qualified by o_w_valid
- o_fn_err  output  1  reserved function code was executed; qualified by o_w_valid
- o_dd_ack  output  1  one-cycle acknowledge back to the DD source

Behaviour:
- Reset:
  - On reset, o_w_reg, o_md_reg, o_f_reg and o_xtr go to 0.
  - o_w_valid, o_w_zero, o_w_lo_invalid, o_fn_err and o_dd_ack go to 0.
  - Stage-1 registers go to 0, and the stage-1 valid bit goes to 0.
  - Reset overrides i_hold.
  - Reset asserted mid-operation discards any in-flight operation.
- Stage 1 (edge E1):
  - If i_valid=1 and i_hold=0, latch U, V, fn, dest and dd_sample into the stage-1 registers and set s1_valid=1.
  - If i_valid=0 and i_hold=0, clear s1_valid.
- Stage 2 (edge E2, the next edge):
  - If s1_valid=1 and i_hold=0, compute W combinationally from the stage-1 registers.
  - Latch W into o_w_reg.
  - Pulse o_w_valid=1, and set the flag outputs from the new W.
  - Perform the destination write on the same edge.
  - If s1_valid=0, o_w_valid goes to 0 and o_w_reg holds its value.
- Latency and throughput:
  - Latency is 2 edges from input to W and to the MD/F/XTR update.
  - Throughput is one operation per cycle.
- Function codes (u = latched U, v = latched V):
  - 0: u OR v
  - 1: u AND v
  - 2: u XOR v
  - 3: u
  - 4: v
  - 5: {u[7:4], v[3:0]}
  - 6: {v[7:4], u[3:0]}
  - 7: {u[3:0], u[7:4]} (nibble swap)
  - 8: {4'h0, u[7:4]}
  - 9: {u[3:0], 4'h0}
  - 10–15: reserved; W = 0 and o_fn_err = 1 with that o_w_valid pulse.
- Destination codes:
  - 0: no write
  - 1: MD <= W[3:0]
  - 2: F <= W[3:0]
  - 3: XTR <= W
  - 4: MD <= W[7:4] and F <= W[3:0]
  - 5–7: no write, no error
- Hazards:
  - There is no bypass.
  - The upstream block reads o_md_reg, o_f_reg and o_xtr as registered values.
  - An operation issued one cycle after a write to MD, F or XTR sees the old value.
  - Back-to-back writes to the same register: the last one wins, in issue order.
- DD acknowledge:
  - o_dd_ack=1 for exactly one cycle at E2 of an operation whose latched dd_sample=1.
  - Otherwise o_dd_ack=0.
- Hold:
  - While i_hold=1, all registers keep their values, including o_w_valid and o_dd_ack.
  - Inputs presented while i_hold=1 are ignored.
  - Resuming hold completes any in-flight stage-1 operation normally.
  - A pulse output that was 1 when hold was asserted stays 1 for the whole hold and clears on the first non-hold edge with no new completion.

Test Plan:
- Reset: assert reset with hold=1 -> every output reads 0 after one edge.
- Function sweep: U=0x5A, V=0xC3 through fn 0–9 -> W = DB, 42, 99, 5A, C3, 53, CA, A5, 05, A0, each with o_w_valid exactly 2 edges after issue.
- Reserved function: fn=12 -> W=00, o_fn_err=1, o_w_zero=1.
- Destination writes:
  - U=0x7E, fn=3, dest=4 -> MD=7, F=E, o_w_lo_invalid=1.
  - Next operation U=0x33, dest=3 -> XTR=0x33, with MD and F unchanged.
- Back-to-back and hold: issue dest=1 with U=0x01 then U=0x02 on consecutive cycles, and assert hold for 3 cycles between them -> MD=1 then MD=2, the pipeline frozen during hold, and no operation lost or duplicated.
- DD handshake: i_dd_sample=1 with i_valid on one cycle only -> o_dd_ack high for exactly one cycle, 2 edges later; i_dd_sample=1 with i_valid=0 -> no ack.
